// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - op encoding, FSM state type and sizing defaults shared by the load/store unit
package mem_lsu_pkg;

  // Default memory port width and memory size in bytes
  localparam int LSU_ADDR_W   = 14;
  localparam int LSU_DM_BYTES = 12288;

  // CPU memory op encoding on req_op
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;
  localparam logic [2:0] OP_LH  = 3'd5;
  localparam logic [2:0] OP_LHU = 3'd6;
  localparam logic [2:0] OP_SH  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS0 = 2'd1,
    ST_ACCESS1 = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_t;

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic op_is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - request/response handshake and data-memory port bundle of the load/store unit
interface mem_lsu_if
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
);

  // CPU request
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  // CPU response
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  // Data memory port
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_we;
  logic              dm_islb;
  logic              dm_issb;
  logic [31:0]       dm_dout;

  // The LSU: target of CPU requests, initiator toward the memory
  modport master (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, dm_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           dm_addr, dm_din, dm_we, dm_islb, dm_issb
  );

  // The surroundings: CPU MEM stage plus data memory
  modport slave (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, dm_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           dm_addr, dm_din, dm_we, dm_islb, dm_issb
  );

endinterface

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit driving dm_1k; halfword ops built only with LSU_HALFWORD_EN
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W   = LSU_ADDR_W,
  parameter int DM_BYTES = LSU_DM_BYTES
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_lsu_if.master bus
);

  lsu_state_t        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]       dm_din_q, dm_din_d;
  logic              dm_we_q, dm_we_d;
  logic              dm_islb_q, dm_islb_d;
  logic              dm_issb_q, dm_issb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef LSU_HALFWORD_EN
  logic [7:0]        low_q, low_d;
  logic [7:0]        wdata_hi_q, wdata_hi_d;
`endif

  logic accept;
  logic req_ok;

  // Alignment and range check; anything above the memory port width is out of range
  function automatic logic req_check(input logic [2:0] op, input logic [31:0] addr);
    logic hi_ok;
    logic ok;
    hi_ok = (addr[31:ADDR_W] == '0);
    ok    = 1'b0;
    case (op)
      OP_LW, OP_SW:          ok = hi_ok && (addr[1:0] == 2'b00) && (addr <= 32'(DM_BYTES - 4));
      OP_LB, OP_LBU, OP_SB:  ok = hi_ok && (addr <= 32'(DM_BYTES - 1));
`ifdef LSU_HALFWORD_EN
      OP_LH, OP_LHU, OP_SH:  ok = hi_ok && !addr[0] && (addr <= 32'(DM_BYTES - 2));
`endif
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign accept = bus.req_valid && (state_q == ST_IDLE);
  assign req_ok = req_check(bus.req_op, bus.req_addr);

  // State and registered outputs; reset clears dm_we at once so no write survives a reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LW;
      dm_addr_q   <= '0;
      dm_din_q    <= '0;
      dm_we_q     <= 1'b0;
      dm_islb_q   <= 1'b0;
      dm_issb_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef LSU_HALFWORD_EN
      low_q       <= '0;
      wdata_hi_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dm_addr_q   <= dm_addr_d;
      dm_din_q    <= dm_din_d;
      dm_we_q     <= dm_we_d;
      dm_islb_q   <= dm_islb_d;
      dm_issb_q   <= dm_issb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LSU_HALFWORD_EN
      low_q       <= low_d;
      wdata_hi_q  <= wdata_hi_d;
`endif
    end
  end

  // Next state: failed checks skip the memory, halfwords take a second access cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = req_ok ? ST_ACCESS0 : ST_RESP;
`ifdef LSU_HALFWORD_EN
      ST_ACCESS0: state_d = op_is_half(op_q) ? ST_ACCESS1 : ST_RESP;
      ST_ACCESS1: state_d = ST_RESP;
`else
      ST_ACCESS0: state_d = ST_RESP;
`endif
      ST_RESP:    if (bus.rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next values of the memory port and response registers for the cycle being entered
  always_comb begin
    op_d        = op_q;
    dm_addr_d   = dm_addr_q;
    dm_din_d    = dm_din_q;
    dm_we_d     = dm_we_q;
    dm_islb_d   = dm_islb_q;
    dm_issb_d   = dm_issb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef LSU_HALFWORD_EN
    low_d       = low_q;
    wdata_hi_d  = wdata_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d        = bus.req_op;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
`ifdef LSU_HALFWORD_EN
          wdata_hi_d  = bus.req_wdata[15:8];
`endif
          if (req_ok) begin
            dm_addr_d = bus.req_addr[ADDR_W-1:0];
            dm_we_d   = op_is_store(bus.req_op);
            dm_islb_d = !op_is_store(bus.req_op) && (bus.req_op != OP_LW);
            dm_issb_d = (bus.req_op == OP_SB) || (bus.req_op == OP_SH);
            if (bus.req_op == OP_SW)
              dm_din_d = bus.req_wdata;
            else if (op_is_store(bus.req_op))
              dm_din_d = {24'b0, bus.req_wdata[7:0]};
            else
              dm_din_d = '0;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
          end
        end
      end
      ST_ACCESS0: begin
        dm_we_d   = 1'b0;
        dm_islb_d = 1'b0;
        dm_issb_d = 1'b0;
        case (op_q)
          OP_LW, OP_LB: rsp_rdata_d = bus.dm_dout;
          OP_LBU:       rsp_rdata_d = {24'b0, bus.dm_dout[7:0]};
          default:      ;
        endcase
`ifdef LSU_HALFWORD_EN
        if (op_is_half(op_q)) begin
          low_d     = bus.dm_dout[7:0];
          dm_addr_d = dm_addr_q + ADDR_W'(1);
          dm_islb_d = (op_q != OP_SH);
          dm_we_d   = (op_q == OP_SH);
          dm_issb_d = (op_q == OP_SH);
          if (op_q == OP_SH) dm_din_d = {24'b0, wdata_hi_q};
        end else begin
          rsp_valid_d = 1'b1;
        end
`else
        rsp_valid_d = 1'b1;
`endif
      end
`ifdef LSU_HALFWORD_EN
      ST_ACCESS1: begin
        dm_we_d     = 1'b0;
        dm_islb_d   = 1'b0;
        dm_issb_d   = 1'b0;
        rsp_valid_d = 1'b1;
        if (op_q == OP_LH)
          rsp_rdata_d = {{16{bus.dm_dout[7]}}, bus.dm_dout[7:0], low_q};
        else if (op_q == OP_LHU)
          rsp_rdata_d = {16'b0, bus.dm_dout[7:0], low_q};
      end
`endif
      ST_RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.dm_addr   = dm_addr_q;
  assign bus.dm_din    = dm_din_q;
  assign bus.dm_we     = dm_we_q;
  assign bus.dm_islb   = dm_islb_q;
  assign bus.dm_issb   = dm_issb_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed and randomized self-checking bench for mem_lsu with a dm_1k model
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int AW = LSU_ADDR_W;
  localparam int NB = LSU_DM_BYTES;
`ifdef LSU_HALFWORD_EN
  localparam bit HW_EN = 1'b1;
`else
  localparam bit HW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic init_mem;

  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(AW)) bus ();

  mem_lsu #(.ADDR_W(AW), .DM_BYTES(NB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [7:0] dm_mem  [NB];
  logic [7:0] ref_mem [NB];
  int n_vec = 0;
  int n_err = 0;
  int we_total = 0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 5));
  endfunction

  // dm_1k model: combinational read with sign-extended byte option
  always_comb begin
    bus.dm_dout = '0;
    if (bus.dm_islb) begin
      if (int'(bus.dm_addr) < NB)
        bus.dm_dout = {{24{dm_mem[int'(bus.dm_addr)][7]}}, dm_mem[int'(bus.dm_addr)]};
    end else if (int'(bus.dm_addr) + 3 < NB) begin
      bus.dm_dout = {dm_mem[int'(bus.dm_addr) + 3], dm_mem[int'(bus.dm_addr) + 2],
                     dm_mem[int'(bus.dm_addr) + 1], dm_mem[int'(bus.dm_addr)]};
    end
  end

  // dm_1k model: synchronous word or byte write
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < NB; i++) dm_mem[i] <= init_byte(i);
    end else if (bus.dm_we === 1'b1) begin
      if (bus.dm_issb) begin
        if (int'(bus.dm_addr) < NB) dm_mem[int'(bus.dm_addr)] <= bus.dm_din[7:0];
      end else if (int'(bus.dm_addr) + 3 < NB) begin
        dm_mem[int'(bus.dm_addr)]     <= bus.dm_din[7:0];
        dm_mem[int'(bus.dm_addr) + 1] <= bus.dm_din[15:8];
        dm_mem[int'(bus.dm_addr) + 2] <= bus.dm_din[23:16];
        dm_mem[int'(bus.dm_addr) + 3] <= bus.dm_din[31:24];
      end
    end
  end

  // Count write-enable cycles
  always @(negedge clk) begin
    if (bus.dm_we === 1'b1) we_total <= we_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    case (op)
      OP_LW, OP_SW:         return 4;
      OP_LB, OP_LBU, OP_SB: return 1;
      default:              return 2;
    endcase
  endfunction

  // Reference: access of op_size bytes, little endian, must be size-aligned and lie inside memory
  task automatic ref_exec(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] e_rd, output logic e_er, output int e_lat,
                          output int e_we);
    int size;
    longint a;
    logic [31:0] v;
    bit store;
    size  = op_size(op);
    a     = {32'd0, addr};
    store = (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    e_rd  = '0;
    e_er  = 1'b0;
    e_we  = 0;
    e_lat = (size == 2) ? 3 : 2;
    if ((size == 2 && !HW_EN) || (a % size) != 0 || a + size > NB) begin
      e_er  = 1'b1;
      e_lat = 1;
    end else if (store) begin
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wdata[8*i +: 8];
      e_we = (size == 2) ? 2 : 1;
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (op == OP_LB && v[7])  v = v | 32'hFFFF_FF00;
      if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
      e_rd = v;
    end
  endtask

  // One transaction; optional response stall of 'hold' cycles, or rsp_ready raised early
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input bit early, output logic [31:0] rd, output logic er);
    logic [31:0] e_rd;
    logic e_er;
    int e_lat, e_we, lat, t, we0;
    ref_exec(op, addr, wdata, e_rd, e_er, e_lat, e_we);
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = early;
    we0 = we_total;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    check("latency", 32'(lat), 32'(e_lat));
    check("rsp_err", 32'(er), 32'(e_er));
    check("rsp_rdata", rd, e_rd);
    check("we_cycles", 32'(we_total - we0), 32'(e_we));
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = OP_SW;
      bus.req_addr  = 32'h100;
      bus.req_wdata = $urandom;
      @(posedge clk); #1;
      check("hold_ctrl", {29'b0, bus.rsp_valid, bus.req_ready, bus.rsp_err}, {29'b0, 1'b1, 1'b0, e_er});
      check("hold_rdata", bus.rsp_rdata, e_rd);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("release_idle", {30'b0, bus.rsp_valid, bus.req_ready}, 32'd1);
    if (hold > 0) check("hold_no_write", 32'(we_total - we0), 32'(e_we));
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic [2:0] rop;
    logic [31:0] ra;
    int diffs;
    rst_n         = 1'b0;
    init_mem      = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NB; i++) ref_mem[i] = init_byte(i);
    @(posedge clk); #1;
    init_mem = 1'b0;

    check("reset_ctrl", {26'b0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.dm_we,
                         bus.dm_islb, bus.dm_issb}, 32'h20);
    check("reset_rdata", bus.rsp_rdata, 32'd0);
    check("reset_dm_addr", 32'(bus.dm_addr), 32'd0);
    check("reset_dm_din", bus.dm_din, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(OP_SW, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, rd, er);
    check("sw_bytes", {dm_mem[16'h13], dm_mem[16'h12], dm_mem[16'h11], dm_mem[16'h10]}, 32'hDEAD_BEEF);
    run_op(OP_LW, 32'h10, 32'h0, 0, 1'b0, rd, er);
    check("lw_value", rd, 32'hDEAD_BEEF);

    run_op(OP_SB, 32'h21, 32'h0000_0085, 0, 1'b0, rd, er);
    run_op(OP_LB, 32'h21, 32'h0, 0, 1'b0, rd, er);
    check("lb_value", rd, 32'hFFFF_FF85);
    run_op(OP_LBU, 32'h21, 32'h0, 0, 1'b0, rd, er);
    check("lbu_value", rd, 32'h0000_0085);
    check("sb_neighbours", {16'b0, dm_mem[16'h22], dm_mem[16'h20]}, {16'b0, init_byte(32'h22), init_byte(32'h20)});

    run_op(OP_LW, 32'h12, 32'h0, 0, 1'b0, rd, er);
    check("lw_misaligned_err", 32'(er), 32'd1);
    run_op(OP_LB, 32'd12288, 32'h0, 0, 1'b0, rd, er);
    check("lb_range_err", 32'(er), 32'd1);
    run_op(OP_SW, 32'd12284, 32'h0BAD_F00D, 0, 1'b0, rd, er);
    check("sw_top_ok", 32'(er), 32'd0);
    run_op(OP_LW, 32'd12284, 32'h0, 0, 1'b1, rd, er);
    run_op(OP_LB, 32'd12287, 32'h0, 0, 1'b0, rd, er);
    run_op(OP_LW, 32'h0001_0010, 32'h0, 0, 1'b0, rd, er);
    run_op(OP_SB, 32'h8000_0001, 32'h77, 0, 1'b0, rd, er);

    run_op(OP_SH, 32'h40, 32'h0000_A1B2, 0, 1'b0, rd, er);
    run_op(OP_LH, 32'h40, 32'h0, 0, 1'b0, rd, er);
`ifdef LSU_HALFWORD_EN
    check("lh_value", rd, 32'hFFFF_A1B2);
`else
    check("lh_disabled_err", 32'(er), 32'd1);
    check("sh_disabled_mem", {16'b0, dm_mem[16'h41], dm_mem[16'h40]}, {16'b0, init_byte(32'h41), init_byte(32'h40)});
`endif
    run_op(OP_LHU, 32'h40, 32'h0, 0, 1'b0, rd, er);
    run_op(OP_LH, 32'd12286, 32'h0, 0, 1'b0, rd, er);
    run_op(OP_SH, 32'd12287, 32'h1234, 0, 1'b0, rd, er);

    run_op(OP_LW, 32'h10, 32'h0, 5, 1'b0, rd, er);
    run_op(OP_LB, 32'h3, 32'h0, 3, 1'b0, rd, er);

    // reset during the write cycle of a store
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SW;
    bus.req_addr  = 32'h80;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_pre_we", 32'(bus.dm_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {26'b0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.dm_we,
                             bus.dm_islb, bus.dm_issb}, 32'h20);
    check("rst_async_addr", 32'(bus.dm_addr), 32'd0);
    check("rst_async_din", bus.dm_din, 32'd0);
    check("rst_async_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_word_kept", {dm_mem[16'h83], dm_mem[16'h82], dm_mem[16'h81], dm_mem[16'h80]},
          {ref_mem[16'h83], ref_mem[16'h82], ref_mem[16'h81], ref_mem[16'h80]});
    check("rst_ready", 32'(bus.req_ready), 32'd1);

    for (int n = 0; n < 300; n++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1:    ra = 32'(NB - int'($urandom_range(1, 6)));
        2:       ra = $urandom;
        default: ra = $urandom_range(0, 255) + ($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, NB - 1)) : 32'h0);
      endcase
      if ($urandom_range(0, 4) != 0) ra = ra & ~32'(op_size(rop) - 1);
      run_op(rop, ra, $urandom, 0, ($urandom_range(0, 3) == 0), rd, er);
    end

    diffs = 0;
    for (int i = 0; i < NB; i++) if (dm_mem[i] !== ref_mem[i]) diffs++;
    check("mem_final", 32'(diffs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
